// File: rtl/aes_pkg.sv
// Shared AES constants and helpers used by the key schedule and the round datapath.
// Provides the round/key-word counts, the Rcon table, the word/round-key types and
// the forward S-box lookup.
package aes_pkg;

  localparam int unsigned AES_NR = 14;
  localparam int unsigned AES_NK = 8;

  typedef logic [31:0]  rk_word_t;
  typedef logic [127:0] round_key_t;

  // Rcon for even round-key indices 2,4,...,14 (only the MS byte is non-zero).
  localparam logic [7:0] AES_RCON [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [10:0] base;
    // Entry x sits at bit 8*(255-x); 255-x is simply ~x.
    base = {~x, 3'b000};
    return AES_SBOX[base +: 8];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word. Purely combinational.
//   word_i  32-bit input word
//   word_o  32-bit substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  rk_word_t word_i,
  output rk_word_t word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      word_o[8*b +: 8] = aes_sbox(word_i[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand_256.sv
// Sequential AES-256 key schedule. Loads RK0/RK1 from the cipher key on an accepted
// start, then generates RK2..RK14 one per cycle into a 15-entry flop key file.
//   inClk/inRst          clock, asynchronous active-high reset
//   inKey/inStart        256-bit cipher key and start request (ignored while busy)
//   inRdIdx0/inRdIdx1    read indices; outKey0/outKey1 are combinational, 0 for idx > 14
//   outBusy              expansion in progress
//   outDone              one-cycle pulse after RK14 is written
//   outKeyValid          all 15 round keys valid
module aes_key_expand_256
  import aes_pkg::*;
(
  input  logic         inClk,
  input  logic         inRst,
  input  logic [255:0] inKey,
  input  logic         inStart,
  input  logic [3:0]   inRdIdx0,
  input  logic [3:0]   inRdIdx1,
  output logic [127:0] outKey0,
  output logic [127:0] outKey1,
  output logic         outBusy,
  output logic         outDone,
  output logic         outKeyValid
);

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic       start_acc, gen_we;

  round_key_t rk_q [AES_NR+1];
  round_key_t prev1, prev2, new_rk;
  rk_word_t   last_w, sub_in, sub_out, t;
  rk_word_t   w0, w1, w2, w3;
  logic [2:0] rcon_idx;
  logic [7:0] rcon_byte;

  // Key-file muxes: the two previous keys for generation plus the two read ports.
  always_comb begin
    prev1   = '0;
    prev2   = '0;
    outKey0 = '0;
    outKey1 = '0;
    for (int i = 0; i <= int'(AES_NR); i++) begin
      if (idx_q == 4'(i + 1)) prev1 = rk_q[i];
      if (inRdIdx0 == 4'(i)) outKey0 = rk_q[i];
      if (inRdIdx1 == 4'(i)) outKey1 = rk_q[i];
    end
    for (int i = 0; i <= int'(AES_NR) - 2; i++) begin
      if (idx_q == 4'(i + 2)) prev2 = rk_q[i];
    end
  end

  // Even indices rotate and add Rcon; odd indices only substitute.
  assign last_w    = prev1[31:0];
  assign sub_in    = idx_q[0] ? last_w : {last_w[23:0], last_w[31:24]};
  assign rcon_idx  = idx_q[3:1] - 3'd1;
  assign rcon_byte = (rcon_idx < 3'd7) ? AES_RCON[rcon_idx] : 8'h00;
  assign t         = idx_q[0] ? sub_out : (sub_out ^ {rcon_byte, 24'h0});

  aes_sub_word u_sub_word (
    .word_i(sub_in),
    .word_o(sub_out)
  );

  assign w0     = prev2[127:96] ^ t;
  assign w1     = prev2[95:64] ^ w0;
  assign w2     = prev2[63:32] ^ w1;
  assign w3     = prev2[31:0] ^ w2;
  assign new_rk = {w0, w1, w2, w3};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    start_acc = 1'b0;
    gen_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inStart) begin
          start_acc = 1'b1;
          state_d   = StGen;
          idx_d     = 4'd2;
          valid_d   = 1'b0;
        end
      end
      StGen: begin
        gen_we = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'(AES_NR)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i <= int'(AES_NR); i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      if (start_acc) begin
        rk_q[0] <= inKey[255:128];
        rk_q[1] <= inKey[127:0];
      end else if (gen_we) begin
        for (int i = 2; i <= int'(AES_NR); i++) begin
          if (idx_q == 4'(i)) rk_q[i] <= new_rk;
        end
      end
    end
  end

  assign outBusy     = (state_q == StGen);
  assign outDone     = done_q;
  assign outKeyValid = valid_q;

endmodule

// File: tb/tb_aes_key_expand_256.sv
module tb_aes_key_expand_256;

  logic         inClk = 1'b0;
  logic         inRst;
  logic [255:0] inKey;
  logic         inStart;
  logic [3:0]   inRdIdx0, inRdIdx1;
  logic [127:0] outKey0, outKey1;
  logic         outBusy, outDone, outKeyValid;

  always #5 inClk = ~inClk;

  aes_key_expand_256 dut (
    .inClk      (inClk),
    .inRst      (inRst),
    .inKey      (inKey),
    .inStart    (inStart),
    .inRdIdx0   (inRdIdx0),
    .inRdIdx1   (inRdIdx1),
    .outKey0    (outKey0),
    .outKey1    (outKey1),
    .outBusy    (outBusy),
    .outDone    (outDone),
    .outKeyValid(outKeyValid)
  );

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  typedef struct {
    bit           sel;  // 0: A.3 key, 1: C.3 key
    logic [3:0]   i0;
    logic [127:0] e0;
    logic [3:0]   i1;
    logic [127:0] e1;
  } vec_t;

  logic [127:0] c3_rk [15];
  vec_t         vecs [5];
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  // Pulse start, then check busy/valid at E0, done latency of 13, and the done pulse width.
  task automatic run_expand(input logic [255:0] key, input logic valid_before, input string tag);
    int n;
    bit seen;
    check({tag, " valid before start"}, 128'(outKeyValid), 128'(valid_before));
    inKey   = key;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    check({tag, " busy after E0"}, 128'(outBusy), 128'd1);
    check({tag, " valid after E0"}, 128'(outKeyValid), 128'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (outDone) seen = 1'b1;
    end
    check({tag, " done latency"}, 128'(n), 128'd13);
    check({tag, " busy at done"}, 128'(outBusy), 128'd0);
    check({tag, " valid at done"}, 128'(outKeyValid), 128'd1);
    step();
    check({tag, " done one cycle"}, 128'(outDone), 128'd0);
  endtask

  initial begin
    int loaded;
    int dones;
    int done_step;
    int busy_gaps;
    int n;
    bit seen;

    c3_rk = '{
      128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36
    };
    vecs[0] = '{1'b0, 4'd2,  A3_RK2,          4'd14, A3_RK14};
    vecs[1] = '{1'b0, 4'd0,  KEY_A3[255:128], 4'd1,  KEY_A3[127:0]};
    vecs[2] = '{1'b0, 4'd15, 128'h0,          4'd14, A3_RK14};
    vecs[3] = '{1'b1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, 4'd14,
                128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[4] = '{1'b1, 4'd15, 128'h0,          4'd1,  128'h101112131415161718191a1b1c1d1e1f};

    // Reset state
    inRst    = 1'b1;
    inStart  = 1'b0;
    inKey    = '0;
    inRdIdx0 = 4'd0;
    inRdIdx1 = 4'd5;
    step();
    check("reset busy", 128'(outBusy), 128'd0);
    check("reset done", 128'(outDone), 128'd0);
    check("reset valid", 128'(outKeyValid), 128'd0);
    check("reset key0", outKey0, 128'h0);
    check("reset key1", outKey1, 128'h0);
    inRst = 1'b0;
    step();

    // Directed vectors; a key change triggers a fresh expansion (restart from valid for C.3)
    loaded = -1;
    for (int v = 0; v < 5; v++) begin
      if (int'(vecs[v].sel) != loaded) begin
        run_expand(vecs[v].sel ? KEY_C3 : KEY_A3, loaded >= 0,
                   vecs[v].sel ? "c3" : "a3");
        loaded = int'(vecs[v].sel);
      end
      inRdIdx0 = vecs[v].i0;
      inRdIdx1 = vecs[v].i1;
      #1;
      check($sformatf("vec%0d port0", v), outKey0, vecs[v].e0);
      check($sformatf("vec%0d port1", v), outKey1, vecs[v].e1);
    end

    // Full C.3 readback, both ports on different indices in the same cycle
    for (int i = 0; i < 15; i++) begin
      inRdIdx0 = 4'(i);
      inRdIdx1 = 4'(14 - i);
      #1;
      check($sformatf("c3 rk%0d port0", i), outKey0, c3_rk[i]);
      check($sformatf("c3 rk%0d port1", 14 - i), outKey1, c3_rk[14 - i]);
    end

    // Level start for 20 cycles, key changed mid-GEN
    inKey   = KEY_A3;
    inStart = 1'b1;
    step();
    dones     = 0;
    done_step = -1;
    busy_gaps = 0;
    for (int s = 1; s < 20; s++) begin
      if (s == 5) inKey = KEY_C3;
      step();
      if (s <= 12 && !outBusy) busy_gaps++;
      if (outDone) begin
        dones++;
        if (done_step < 0) begin
          done_step = s;
          inRdIdx0  = 4'd2;
          inRdIdx1  = 4'd14;
          #1;
          check("hold a3 rk2", outKey0, A3_RK2);
          check("hold a3 rk14", outKey1, A3_RK14);
        end
      end
      if (s == 14) begin
        check("hold restart busy", 128'(outBusy), 128'd1);
        check("hold restart valid", 128'(outKeyValid), 128'd0);
      end
    end
    inStart = 1'b0;
    check("hold done count", 128'(dones), 128'd1);
    check("hold done step", 128'(done_step), 128'd13);
    check("hold busy gaps", 128'(busy_gaps), 128'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      step();
      n++;
      if (outDone) seen = 1'b1;
    end
    check("second run done seen", 128'(seen), 128'd1);
    inRdIdx0 = 4'd2;
    inRdIdx1 = 4'd14;
    #1;
    check("second run rk2", outKey0, c3_rk[2]);
    check("second run rk14", outKey1, c3_rk[14]);
    step();

    // Reset in cycle 6 of GEN
    inKey   = KEY_A3;
    inStart = 1'b1;
    step();
    inStart = 1'b0;
    for (int s = 0; s < 6; s++) step();
    inRst = 1'b1;
    #1;
    check("midrst busy", 128'(outBusy), 128'd0);
    check("midrst done", 128'(outDone), 128'd0);
    check("midrst valid", 128'(outKeyValid), 128'd0);
    for (int i = 0; i < 16; i++) begin
      inRdIdx0 = 4'(i);
      inRdIdx1 = 4'(15 - i);
      #1;
      check($sformatf("midrst port0 idx%0d", i), outKey0, 128'h0);
      check($sformatf("midrst port1 idx%0d", 15 - i), outKey1, 128'h0);
    end
    step();
    inRst = 1'b0;
    step();
    run_expand(KEY_A3, 1'b0, "post-reset");
    inRdIdx0 = 4'd2;
    inRdIdx1 = 4'd14;
    #1;
    check("post-reset rk2", outKey0, A3_RK2);
    check("post-reset rk14", outKey1, A3_RK14);
    inRdIdx0 = 4'd1;
    inRdIdx1 = 4'd15;
    #1;
    check("post-reset rk1", outKey0, KEY_A3[127:0]);
    check("post-reset idx15", outKey1, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
